// File: rtl/dest_tag_pipeline_pkg.sv
// Shared types for the destination-tag pipeline: tag record, bubble constant
// and the source/tag match helper used by the hazard logic.
package dest_tag_pipeline_pkg;

  localparam int TAG_REG_W   = 4;
  localparam int STALL_CNT_W = 16;

  typedef struct packed {
    logic [TAG_REG_W-1:0] dest;
    logic                 wb_en;
    logic                 mem_r_en;
  } tag_t;

  localparam tag_t TAG_NOP = '{dest: '0, wb_en: 1'b0, mem_r_en: 1'b0};

  // A bubble can never hit: it carries wb_en = 0.
  function automatic logic tag_hit(input tag_t t, input logic [TAG_REG_W-1:0] src);
    return (src == t.dest) && t.wb_en;
  endfunction

endpackage

// File: rtl/dest_tag_pipeline_if.sv
// ID-side and forwarding-side signals of the destination-tag pipeline.
// master = decode/forwarding side, slave = the tag pipeline itself.
interface dest_tag_pipeline_if #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
);

  logic [REG_W-1:0] ID_Dest;
  logic             ID_WB_EN;
  logic             ID_MEM_R_EN;
  logic [REG_W-1:0] src1;
  logic [REG_W-1:0] src2;
  logic             Two_src;
  logic             forward_en;
  logic             freeze;
  logic             flush;

  logic [REG_W-1:0] EXE_Dest;
  logic             EXE_WB_EN;
  logic             EXE_MEM_R_EN;
  logic [REG_W-1:0] MEM_Dest;
  logic             MEM_WB_EN;
  logic [REG_W-1:0] WB_Dest;
  logic             WB_WB_EN;
  logic             hazard;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output ID_Dest, ID_WB_EN, ID_MEM_R_EN, src1, src2, Two_src,
           forward_en, freeze, flush,
    input  EXE_Dest, EXE_WB_EN, EXE_MEM_R_EN, MEM_Dest, MEM_WB_EN,
           WB_Dest, WB_WB_EN, hazard, stall_cnt
  );

  modport slave (
    input  ID_Dest, ID_WB_EN, ID_MEM_R_EN, src1, src2, Two_src,
           forward_en, freeze, flush,
    output EXE_Dest, EXE_WB_EN, EXE_MEM_R_EN, MEM_Dest, MEM_WB_EN,
           WB_Dest, WB_WB_EN, hazard, stall_cnt
  );

endinterface

// File: rtl/dest_tag_pipeline_tag_stage_reg.sv
// One tag stage register. Priority: hold > bubble > load.
module tag_stage_reg
  import dest_tag_pipeline_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  input  logic bubble,
  input  tag_t d,
  output tag_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= TAG_NOP;
    end else if (!hold) begin
      q <= bubble ? TAG_NOP : d;
    end
  end

endmodule

// File: rtl/dest_tag_pipeline.sv
// Destination-tag tracker for EXE/MEM/WB: exports stage tags to forwarding,
// raises the load-use / no-forward hazard stall and counts stall cycles.
module dest_tag_pipeline
  import dest_tag_pipeline_pkg::*;
#(
  parameter int REG_W = TAG_REG_W,
  parameter int CNT_W = STALL_CNT_W
) (
  input logic               clk,
  input logic               rst_n,
  dest_tag_pipeline_if.slave bus
);

  tag_t             id_tag;
  tag_t             exe_q;
  tag_t             mem_q;
  tag_t             wb_q;
  logic [REG_W-1:0] src1;
  logic [REG_W-1:0] src2;
  logic             hit_exe;
  logic             hit_mem;
  logic             hazard;
  logic             exe_bubble;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             unused_mem_r_en;

  assign id_tag = '{dest: bus.ID_Dest, wb_en: bus.ID_WB_EN, mem_r_en: bus.ID_MEM_R_EN};
  assign src1   = bus.src1;
  assign src2   = bus.src2;

  // WB never stalls: the register file writes in the first half-cycle.
  always_comb begin
    hit_exe = tag_hit(exe_q, src1) || (bus.Two_src && tag_hit(exe_q, src2));
    hit_mem = tag_hit(mem_q, src1) || (bus.Two_src && tag_hit(mem_q, src2));
    hazard  = 1'b0;
    if (bus.forward_en) begin
      hazard = exe_q.mem_r_en && hit_exe;
    end else begin
      hazard = hit_exe || hit_mem;
    end
  end

  // flush and hazard together still insert just one bubble.
  assign exe_bubble = bus.flush || hazard;

  tag_stage_reg u_exe (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (bus.freeze),
    .bubble (exe_bubble),
    .d      (id_tag),
    .q      (exe_q)
  );

  tag_stage_reg u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (bus.freeze),
    .bubble (1'b0),
    .d      (exe_q),
    .q      (mem_q)
  );

  tag_stage_reg u_wb (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (bus.freeze),
    .bubble (1'b0),
    .d      (mem_q),
    .q      (wb_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (!bus.freeze && hazard && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.EXE_Dest     = exe_q.dest;
  assign bus.EXE_WB_EN    = exe_q.wb_en;
  assign bus.EXE_MEM_R_EN = exe_q.mem_r_en;
  assign bus.MEM_Dest     = mem_q.dest;
  assign bus.MEM_WB_EN    = mem_q.wb_en;
  assign bus.WB_Dest      = wb_q.dest;
  assign bus.WB_WB_EN     = wb_q.wb_en;
  assign bus.hazard       = hazard;
  assign bus.stall_cnt    = stall_cnt_q;

  // Load flag is carried past EXE for completeness but nobody downstream reads it.
  assign unused_mem_r_en = mem_q.mem_r_en ^ wb_q.mem_r_en;

endmodule

// File: tb/tb_dest_tag_pipeline.sv
module tb_dest_tag_pipeline;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  dest_tag_pipeline_if #(.REG_W(4), .CNT_W(16)) bus ();
  dest_tag_pipeline_if #(.REG_W(4), .CNT_W(3))  bus_s ();

  dest_tag_pipeline #(.REG_W(4), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Narrow-counter copy shares all stimulus; used to reach saturation quickly.
  dest_tag_pipeline #(.REG_W(4), .CNT_W(3)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s.slave)
  );

  assign bus_s.ID_Dest     = bus.ID_Dest;
  assign bus_s.ID_WB_EN    = bus.ID_WB_EN;
  assign bus_s.ID_MEM_R_EN = bus.ID_MEM_R_EN;
  assign bus_s.src1        = bus.src1;
  assign bus_s.src2        = bus.src2;
  assign bus_s.Two_src     = bus.Two_src;
  assign bus_s.forward_en  = bus.forward_en;
  assign bus_s.freeze      = bus.freeze;
  assign bus_s.flush       = bus.flush;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state: index 0 = EXE, 1 = MEM, 2 = WB
  int m_dest [3];
  int m_wb   [3];
  int m_mr   [3];
  int m_cnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input int dest, input logic wb, input logic mr,
                          input int s1, input int s2, input logic two);
    bus.ID_Dest     = 4'(dest);
    bus.ID_WB_EN    = wb;
    bus.ID_MEM_R_EN = mr;
    bus.src1        = 4'(s1);
    bus.src2        = 4'(s2);
    bus.Two_src     = two;
  endtask

  task automatic set_idle();
    drive_id(0, 1'b0, 1'b0, 15, 15, 1'b0);
    bus.forward_en = 1'b1;
    bus.freeze     = 1'b0;
    bus.flush      = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    #7;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    #3;
    checks++;
    if (bus.EXE_Dest !== 4'd0 || bus.EXE_WB_EN !== 1'b0 || bus.EXE_MEM_R_EN !== 1'b0 ||
        bus.MEM_Dest !== 4'd0 || bus.MEM_WB_EN !== 1'b0 || bus.WB_Dest !== 4'd0 ||
        bus.WB_WB_EN !== 1'b0) begin
      failures++;
      $display("FAIL reset_tags: got exe=%0h/%0b/%0b mem=%0h/%0b wb=%0h/%0b expected all 0",
               bus.EXE_Dest, bus.EXE_WB_EN, bus.EXE_MEM_R_EN, bus.MEM_Dest, bus.MEM_WB_EN,
               bus.WB_Dest, bus.WB_WB_EN);
    end
    checks++;
    if (bus.hazard !== 1'b0 || bus.stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_hazard_cnt: got hazard=%0b cnt=%0d expected 0/0", bus.hazard, bus.stall_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    int exp_wb [6];
    exp_wb = '{0, 0, 0, 1, 2, 3};
    do_reset();
    for (int c = 1; c <= 5; c++) begin
      if (c <= 3) drive_id(c, 1'b1, 1'b0, 15, 15, 1'b0);
      else        drive_id(0, 1'b0, 1'b0, 15, 15, 1'b0);
      #1;
      checks++;
      if (bus.hazard !== 1'b0) begin
        failures++;
        $display("FAIL stream_hazard c%0d: got %0b expected 0", c, bus.hazard);
      end
      tick();
      if (c == 1) begin
        checks++;
        if (bus.EXE_Dest !== 4'd1 || bus.EXE_WB_EN !== 1'b1) begin
          failures++;
          $display("FAIL stream_exe: got %0h/%0b expected 1/1", bus.EXE_Dest, bus.EXE_WB_EN);
        end
      end
      if (c >= 3) begin
        checks++;
        if (bus.WB_Dest !== 4'(exp_wb[c]) || bus.WB_WB_EN !== 1'b1) begin
          failures++;
          $display("FAIL stream_wb c%0d: got %0h/%0b expected %0h/1", c, bus.WB_Dest, bus.WB_WB_EN, exp_wb[c]);
        end
      end
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive_id(5, 1'b1, 1'b1, 15, 15, 1'b0);
    tick();
    drive_id(6, 1'b1, 1'b0, 5, 15, 1'b0);
    #1;
    checks++;
    if (bus.hazard !== 1'b1) begin
      failures++;
      $display("FAIL load_use_hazard: got %0b expected 1", bus.hazard);
    end
    tick();
    checks++;
    if (bus.EXE_WB_EN !== 1'b0 || bus.MEM_Dest !== 4'd5 || bus.hazard !== 1'b0 || bus.stall_cnt !== 16'd1) begin
      failures++;
      $display("FAIL load_use_bubble: got exe_wb=%0b mem=%0h hazard=%0b cnt=%0d expected 0/5/0/1",
               bus.EXE_WB_EN, bus.MEM_Dest, bus.hazard, bus.stall_cnt);
    end
    tick();
    checks++;
    if (bus.EXE_Dest !== 4'd6 || bus.EXE_WB_EN !== 1'b1) begin
      failures++;
      $display("FAIL load_use_resume: got %0h/%0b expected 6/1", bus.EXE_Dest, bus.EXE_WB_EN);
    end
  endtask

  task automatic test_no_fwd(input logic two);
    do_reset();
    bus.forward_en = 1'b0;
    drive_id(7, 1'b1, 1'b0, 15, 15, 1'b0);
    tick();
    drive_id(1, 1'b1, 1'b0, 15, 7, two);
    #1;
    checks++;
    if (bus.hazard !== two) begin
      failures++;
      $display("FAIL nofwd_exe two=%0b: got %0b expected %0b", two, bus.hazard, two);
    end
    tick();
    checks++;
    if (bus.hazard !== two) begin
      failures++;
      $display("FAIL nofwd_mem two=%0b: got %0b expected %0b", two, bus.hazard, two);
    end
    tick();
    checks++;
    if (bus.hazard !== 1'b0 || bus.stall_cnt !== (two ? 16'd2 : 16'd0)) begin
      failures++;
      $display("FAIL nofwd_end two=%0b: got hazard=%0b cnt=%0d expected 0/%0d",
               two, bus.hazard, bus.stall_cnt, two ? 2 : 0);
    end
    set_idle();
  endtask

  task automatic test_freeze();
    do_reset();
    drive_id(9, 1'b1, 1'b0, 15, 15, 1'b0);
    tick();
    drive_id(4, 1'b1, 1'b0, 15, 15, 1'b0);
    tick();
    drive_id(0, 1'b0, 1'b0, 15, 15, 1'b0);
    tick();
    bus.freeze = 1'b1;
    drive_id(11, 1'b1, 1'b0, 15, 15, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.MEM_Dest !== 4'd4 || bus.WB_Dest !== 4'd9 || bus.WB_WB_EN !== 1'b1 || bus.EXE_WB_EN !== 1'b0) begin
        failures++;
        $display("FAIL freeze_hold %0d: got mem=%0h wb=%0h/%0b exe_wb=%0b expected 4/9/1/0",
                 i, bus.MEM_Dest, bus.WB_Dest, bus.WB_WB_EN, bus.EXE_WB_EN);
      end
    end
    bus.freeze = 1'b0;
    tick();
    checks++;
    if (bus.WB_Dest !== 4'd4 || bus.EXE_Dest !== 4'd11) begin
      failures++;
      $display("FAIL freeze_release: got wb=%0h exe=%0h expected 4/b", bus.WB_Dest, bus.EXE_Dest);
    end
    set_idle();
  endtask

  task automatic test_flush_freeze();
    do_reset();
    drive_id(3, 1'b1, 1'b0, 15, 15, 1'b0);
    tick();
    drive_id(8, 1'b1, 1'b0, 15, 15, 1'b0);
    bus.flush  = 1'b1;
    bus.freeze = 1'b1;
    tick();
    checks++;
    if (bus.EXE_Dest !== 4'd3 || bus.EXE_WB_EN !== 1'b1 || bus.MEM_WB_EN !== 1'b0) begin
      failures++;
      $display("FAIL flush_frozen: got exe=%0h/%0b mem_wb=%0b expected 3/1/0",
               bus.EXE_Dest, bus.EXE_WB_EN, bus.MEM_WB_EN);
    end
    bus.freeze = 1'b0;
    tick();
    checks++;
    if (bus.EXE_WB_EN !== 1'b0 || bus.EXE_Dest !== 4'd0 || bus.MEM_Dest !== 4'd3 || bus.stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL flush_unfrozen: got exe=%0h/%0b mem=%0h cnt=%0d expected 0/0/3/0",
               bus.EXE_Dest, bus.EXE_WB_EN, bus.MEM_Dest, bus.stall_cnt);
    end
    bus.flush = 1'b0;
    tick();
    checks++;
    if (bus.EXE_Dest !== 4'd8 || bus.EXE_WB_EN !== 1'b1) begin
      failures++;
      $display("FAIL flush_resume: got %0h/%0b expected 8/1", bus.EXE_Dest, bus.EXE_WB_EN);
    end
    set_idle();
  endtask

  task automatic test_async_reset();
    do_reset();
    drive_id(4, 1'b1, 1'b1, 15, 15, 1'b0);
    tick();
    drive_id(5, 1'b1, 1'b0, 4, 15, 1'b0);
    tick();
    tick();
    drive_id(6, 1'b1, 1'b0, 15, 15, 1'b0);
    tick();
    tick();
    checks++;
    if (bus.EXE_Dest !== 4'd6 || bus.MEM_Dest !== 4'd6 || bus.WB_Dest !== 4'd5 || bus.stall_cnt !== 16'd1) begin
      failures++;
      $display("FAIL areset_pre: got exe=%0h mem=%0h wb=%0h cnt=%0d expected 6/6/5/1",
               bus.EXE_Dest, bus.MEM_Dest, bus.WB_Dest, bus.stall_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.EXE_Dest !== 4'd0 || bus.EXE_WB_EN !== 1'b0 || bus.MEM_Dest !== 4'd0 || bus.MEM_WB_EN !== 1'b0 ||
        bus.WB_Dest !== 4'd0 || bus.WB_WB_EN !== 1'b0 || bus.stall_cnt !== 16'd0 || bus.hazard !== 1'b0) begin
      failures++;
      $display("FAIL areset_clear: got exe=%0h mem=%0h wb=%0h cnt=%0d hazard=%0b expected all 0",
               bus.EXE_Dest, bus.MEM_Dest, bus.WB_Dest, bus.stall_cnt, bus.hazard);
    end
    set_idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // self-dependent instruction: load, stall, stall repeats -> 10 stalls in 15 edges
  task automatic test_saturation();
    do_reset();
    bus.forward_en = 1'b0;
    drive_id(7, 1'b1, 1'b0, 7, 15, 1'b0);
    repeat (15) tick();
    checks++;
    if (bus.stall_cnt !== 16'd10) begin
      failures++;
      $display("FAIL sat_wide: got %0d expected 10", bus.stall_cnt);
    end
    checks++;
    if (bus_s.stall_cnt !== 3'd7) begin
      failures++;
      $display("FAIL sat_narrow: got %0d expected 7", bus_s.stall_cnt);
    end
    set_idle();
  endtask

  function automatic logic hit(input int st, input int s);
    return (m_wb[st] != 0) && (m_dest[st] == s);
  endfunction

  task automatic test_random();
    int   id_d, s1, s2;
    logic id_wb, id_mr, two, fwd, frz, fl, exp_haz;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      m_dest[k] = 0; m_wb[k] = 0; m_mr[k] = 0;
    end
    m_cnt = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      id_d  = int'($urandom_range(0, 3));
      id_wb = 1'($urandom_range(0, 1));
      id_mr = id_wb & 1'($urandom_range(0, 1));
      s1    = int'($urandom_range(0, 3));
      s2    = int'($urandom_range(0, 3));
      two   = 1'($urandom_range(0, 1));
      fwd   = ($urandom_range(0, 3) != 0);
      frz   = ($urandom_range(0, 4) == 0);
      fl    = ($urandom_range(0, 6) == 0);
      drive_id(id_d, id_wb, id_mr, s1, s2, two);
      bus.forward_en = fwd;
      bus.freeze     = frz;
      bus.flush      = fl;
      #1;
      if (fwd) exp_haz = (m_mr[0] != 0) && (hit(0, s1) || (two && hit(0, s2)));
      else     exp_haz = hit(0, s1) || (two && hit(0, s2)) || hit(1, s1) || (two && hit(1, s2));
      checks++;
      if (bus.hazard !== exp_haz) begin
        failures++;
        $display("FAIL rnd_hazard cyc%0d: got %0b expected %0b", cyc, bus.hazard, exp_haz);
      end
      checks++;
      if (bus.EXE_Dest !== 4'(m_dest[0]) || bus.EXE_WB_EN !== 1'(m_wb[0]) || bus.EXE_MEM_R_EN !== 1'(m_mr[0])) begin
        failures++;
        $display("FAIL rnd_exe cyc%0d: got %0h/%0b/%0b expected %0h/%0d/%0d", cyc,
                 bus.EXE_Dest, bus.EXE_WB_EN, bus.EXE_MEM_R_EN, m_dest[0], m_wb[0], m_mr[0]);
      end
      checks++;
      if (bus.MEM_Dest !== 4'(m_dest[1]) || bus.MEM_WB_EN !== 1'(m_wb[1])) begin
        failures++;
        $display("FAIL rnd_mem cyc%0d: got %0h/%0b expected %0h/%0d", cyc, bus.MEM_Dest, bus.MEM_WB_EN, m_dest[1], m_wb[1]);
      end
      checks++;
      if (bus.WB_Dest !== 4'(m_dest[2]) || bus.WB_WB_EN !== 1'(m_wb[2])) begin
        failures++;
        $display("FAIL rnd_wb cyc%0d: got %0h/%0b expected %0h/%0d", cyc, bus.WB_Dest, bus.WB_WB_EN, m_dest[2], m_wb[2]);
      end
      checks++;
      if (bus.stall_cnt !== 16'(m_cnt)) begin
        failures++;
        $display("FAIL rnd_cnt cyc%0d: got %0d expected %0d", cyc, bus.stall_cnt, m_cnt);
      end
      checks++;
      if (bus_s.stall_cnt !== 3'((m_cnt > 7) ? 7 : m_cnt)) begin
        failures++;
        $display("FAIL rnd_cnt_sat cyc%0d: got %0d expected %0d", cyc, bus_s.stall_cnt, (m_cnt > 7) ? 7 : m_cnt);
      end
      if (!frz) begin
        if (exp_haz && m_cnt < 65535) m_cnt++;
        for (int k = 2; k > 0; k--) begin
          m_dest[k] = m_dest[k-1]; m_wb[k] = m_wb[k-1]; m_mr[k] = m_mr[k-1];
        end
        if (fl || exp_haz) begin
          m_dest[0] = 0; m_wb[0] = 0; m_mr[0] = 0;
        end else begin
          m_dest[0] = id_d; m_wb[0] = int'(id_wb); m_mr[0] = int'(id_mr);
        end
      end
      tick();
    end
    set_idle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    set_idle();
    #2;
    test_reset();
    test_stream();
    test_load_use();
    test_no_fwd(1'b1);
    test_no_fwd(1'b0);
    test_freeze();
    test_flush_freeze();
    test_async_reset();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
